bk_adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit approximate Brent-Kung adder datapath (lower K bits carry-truncated) between several requesters. It accepts operand pairs over per-requester valid/ready handshakes, runs one addition at a time, and returns a registered result with the winning requester's ID. It sits between operand-producing blocks and the shared approximate adder in the AxPPA adder subsystem.

---
 rtl/bk_adder_pkg.sv | 36 +++
 rtl/bk_adder_arbiter_if.sv | 45 ++++
 rtl/bk_approx_add_core.sv | 89 ++++++++
 rtl/bk_adder_arbiter.sv | 137 +++++++++++++
 tb/tb_bk_adder_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bk_adder_pkg.sv
// Shared types and helpers for the round-robin approximate-adder arbiter.
package bk_adder_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_APPROX_K = 8;
  localparam int MAX_REQ      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_search(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0] ptr,
                                         input int n);
    rr_pick_t pick;
    int       cand;
    pick = '0;
    for (int off = 0; off < MAX_REQ; off++) begin
      cand = (int'(ptr) + off) % n;
      if (off < n && !pick.found && valid[3'(cand)]) begin
        pick.found = 1'b1;
        pick.idx   = 3'(cand);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bk_adder_arbiter_if.sv
// Requester/response bus of the shared approximate adder.
// Optional error-monitor signals appear when BK_ERR_MON_EN is defined.
interface bk_adder_arbiter_if
  import bk_adder_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [IDW-1:0]           resp_id;
  logic [WIDTH-1:0]         resp_sum;
  logic                     resp_cout;
`ifdef BK_ERR_MON_EN
  logic                     err_flag;
  logic [31:0]              err_count;
  logic [WIDTH:0]           err_dist_max;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_cout,
    input  err_flag, err_count, err_dist_max
  );
  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_cout,
    output err_flag, err_count, err_dist_max
  );
`else
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );
  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );
`endif
endinterface

// File: rtl/bk_approx_add_core.sv
// Combinational approximate adder: low APPROX_K bits use a one-bit carry look-back,
// upper bits are an exact Brent-Kung prefix adder seeded by a[K-1]&b[K-1].
module bk_approx_add_core
  import bk_adder_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int APPROX_K = DEF_APPROX_K
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  localparam int UW  = WIDTH - APPROX_K;
  localparam int LV  = (UW > 1) ? $clog2(UW) : 0;
  localparam int NST = (LV == 0) ? 0 : 2 * LV - 1;

  logic          w_cin;
  logic [UW-1:0] w_p0, w_g0, w_carry;
  logic          w_unused_p;

  assign w_cin = i_a[APPROX_K-1] & i_b[APPROX_K-1];

  genvar gi, gs;
  generate
    for (gi = 0; gi < APPROX_K; gi++) begin : g_lo
      if (gi == 0) begin : g_b0
        assign o_sum[gi] = i_a[gi] ^ i_b[gi];
      end else begin : g_bn
        assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ (i_a[gi-1] & i_b[gi-1]);
      end
    end

    // Carry-in is folded into bit 0 so every prefix generate is a carry-out.
    for (gi = 0; gi < UW; gi++) begin : g_pg
      assign w_p0[gi] = i_a[APPROX_K+gi] ^ i_b[APPROX_K+gi];
      if (gi == 0) begin : g_g0
        assign w_g0[gi] = (i_a[APPROX_K] & i_b[APPROX_K]) | (w_p0[gi] & w_cin);
      end else begin : g_gn
        assign w_g0[gi] = i_a[APPROX_K+gi] & i_b[APPROX_K+gi];
      end
    end

    // Stages 0..LV-1 are the up-sweep, the remaining ones the down-sweep.
    for (gs = 0; gs < NST; gs++) begin : g_stage
      localparam bit UP   = (gs < LV);
      localparam int LVL  = UP ? gs : (LV - 2 - (gs - LV));
      localparam int SPAN = 1 << LVL;
      logic [UW-1:0] g_in, p_in, g_out, p_out;
      if (gs == 0) begin : g_first
        assign g_in = w_g0;
        assign p_in = w_p0;
      end else begin : g_next
        assign g_in = g_stage[gs-1].g_out;
        assign p_in = g_stage[gs-1].p_out;
      end
      for (gi = 0; gi < UW; gi++) begin : g_node
        localparam bit COMB = UP ? (((gi + 1) % (2 * SPAN)) == 0)
                                 : ((((gi + 1) % (2 * SPAN)) == SPAN) && (gi >= 2 * SPAN));
        if (COMB) begin : g_dot
          assign g_out[gi] = g_in[gi] | (p_in[gi] & g_in[gi-SPAN]);
          assign p_out[gi] = p_in[gi] & p_in[gi-SPAN];
        end else begin : g_pass
          assign g_out[gi] = g_in[gi];
          assign p_out[gi] = p_in[gi];
        end
      end
    end

    if (NST == 0) begin : g_carry_direct
      assign w_carry    = w_g0;
      assign w_unused_p = 1'b0;
    end else begin : g_carry_tree
      assign w_carry    = g_stage[NST-1].g_out;
      assign w_unused_p = ^g_stage[NST-1].p_out;
    end

    for (gi = 0; gi < UW; gi++) begin : g_hi
      if (gi == 0) begin : g_s0
        assign o_sum[APPROX_K+gi] = w_p0[gi] ^ w_cin;
      end else begin : g_sn
        assign o_sum[APPROX_K+gi] = w_p0[gi] ^ w_carry[gi-1];
      end
    end
  endgenerate

  assign o_cout = w_carry[UW-1];

endmodule

// File: rtl/bk_adder_arbiter.sv
// Round-robin arbiter sequencing one shared approximate adder (IDLE -> CALC -> RESP).
// Define BK_ERR_MON_EN to add the exact-sum error monitor outputs.
module bk_adder_arbiter
  import bk_adder_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int APPROX_K = DEF_APPROX_K
) (
  input logic               clk,
  input logic               rst,
  bk_adder_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state, w_state_next;
  logic [IDW-1:0]     r_rr_ptr, r_op_id, r_resp_id, w_ptr_next;
  logic [WIDTH-1:0]   r_op_a, r_op_b, r_resp_sum;
  logic               r_resp_cout, r_resp_valid;
  rr_pick_t           w_pick;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_grant;
  logic [WIDTH-1:0]   w_slot_a [NUM_REQ];
  logic [WIDTH-1:0]   w_slot_b [NUM_REQ];
  logic [WIDTH-1:0]   w_core_sum;
  logic               w_core_cout;
  logic               w_resp_hs;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign w_slot_a[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign w_slot_b[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_pick     = rr_search(MAX_REQ'(bus.req_valid), 3'(r_rr_ptr), NUM_REQ);
  assign w_ptr_next = (w_pick.idx == 3'(NUM_REQ - 1)) ? '0 : IDW'(w_pick.idx + 3'd1);
  assign w_resp_hs  = (r_state == RESP) && bus.resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Grant is held off while rst is high so nothing is accepted during reset.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_grant      = '0;
    case (r_state)
      IDLE: begin
        if (w_pick.found && !rst) begin
          w_accept                     = 1'b1;
          w_grant[w_pick.idx[IDW-1:0]] = 1'b1;
          w_state_next                 = CALC;
        end
      end
      CALC:    w_state_next = RESP;
      RESP:    if (bus.resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  bk_approx_add_core #(
    .WIDTH    (WIDTH),
    .APPROX_K (APPROX_K)
  ) u_core (
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .o_sum  (w_core_sum),
    .o_cout (w_core_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_op_id      <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_resp_id    <= '0;
      r_resp_sum   <= '0;
      r_resp_cout  <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a   <= w_slot_a[w_pick.idx[IDW-1:0]];
        r_op_b   <= w_slot_b[w_pick.idx[IDW-1:0]];
        r_op_id  <= w_pick.idx[IDW-1:0];
        r_rr_ptr <= w_ptr_next;
      end
      if (r_state == CALC) begin
        r_resp_sum   <= w_core_sum;
        r_resp_cout  <= w_core_cout;
        r_resp_id    <= r_op_id;
        r_resp_valid <= 1'b1;
      end
      if (w_resp_hs) r_resp_valid <= 1'b0;
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_sum   = r_resp_sum;
  assign bus.resp_cout  = r_resp_cout;

`ifdef BK_ERR_MON_EN
  logic [WIDTH:0] w_exact, w_approx, w_dist;
  logic           r_err_flag;
  logic [31:0]    r_err_count;
  logic [WIDTH:0] r_err_dist_max;

  assign w_exact  = {1'b0, r_op_a} + {1'b0, r_op_b};
  assign w_approx = {w_core_cout, w_core_sum};
  assign w_dist   = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_flag     <= 1'b0;
      r_err_count    <= '0;
      r_err_dist_max <= '0;
    end else begin
      if (r_state == CALC) begin
        r_err_flag <= (w_exact != w_approx);
        if (w_dist > r_err_dist_max) r_err_dist_max <= w_dist;
      end
      if (w_resp_hs && r_err_flag && (r_err_count != '1)) r_err_count <= r_err_count + 32'd1;
    end
  end

  assign bus.err_flag     = r_err_flag;
  assign bus.err_count    = r_err_count;
  assign bus.err_dist_max = r_err_dist_max;
`endif

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Directed-table, corner-sequence and random-operand bench for bk_adder_arbiter.
module tb_bk_adder_arbiter;
  localparam int NR = 4;
  localparam int W  = 16;
  localparam int K  = 8;

  typedef struct {
    logic [NR-1:0] mask;
    int            id;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  sum;
    logic          cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   m_err_cnt = 0;
  logic [W:0] m_dist_max = '0;

  always #5 clk = ~clk;

  bk_adder_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  bk_adder_arbiter #(.NUM_REQ(NR), .WIDTH(W), .APPROX_K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [K-1:0] lo;
    logic [W:0]   hi;
    for (int i = 0; i < K; i++)
      lo[i] = a[i] ^ b[i] ^ ((i > 0) ? (a[i-1] & b[i-1]) : 1'b0);
    hi = (W+1)'(a >> K) + (W+1)'(b >> K) + (W+1)'(a[K-1] & b[K-1]);
    return {hi[W-K:0], lo};
  endfunction

  // Called one tick after an edge with the DUT in IDLE; returns in IDLE after the handshake.
  task automatic run_vec(input logic [NR-1:0] mask, input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] esum, input logic ecout);
    logic [W:0] ex, ap, d;
    ex = (W+1)'(a) + (W+1)'(b);
    ap = {ecout, esum};
    d  = (ex >= ap) ? (ex - ap) : (ap - ex);
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*W +: W] = (i == id) ? a : W'($urandom);
      bus.req_b[i*W +: W] = (i == id) ? b : W'($urandom);
    end
    bus.req_valid  = mask;
    bus.resp_ready = 1'b1;
    #1 chk("grant", 64'(bus.req_ready), 64'(4'b0001 << id));
    tick();
    bus.req_valid = '0;
    #1 chk("calc_quiet", {bus.req_ready, bus.resp_valid}, 0);
    tick();
    chk("resp_valid", 64'(bus.resp_valid), 1);
    chk("resp_id", 64'(bus.resp_id), 64'(id));
    chk("resp_sum", 64'(bus.resp_sum), 64'(esum));
    chk("resp_cout", 64'(bus.resp_cout), 64'(ecout));
`ifdef BK_ERR_MON_EN
    if (d > m_dist_max) m_dist_max = d;
    chk("err_flag", 64'(bus.err_flag), 64'(ex != ap));
    chk("err_dist_max", 64'(bus.err_dist_max), 64'(m_dist_max));
    if (ex != ap) m_err_cnt++;
`endif
    $display("txn id=%0d a=%h b=%h sum=%h cout=%0d", id, a, b, bus.resp_sum, bus.resp_cout);
    tick();
`ifdef BK_ERR_MON_EN
    chk("err_count", 64'(bus.err_count), 64'(m_err_cnt));
`endif
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_err_cnt  = 0;
    m_dist_max = '0;
  endtask

  vec_t vecs[7];

  initial begin
    int         gcnt;
    int         last_cyc;
    int         gid;
    logic [W-1:0] hold_sum;
    logic [W:0]   r;
    int           rid;
    logic [W-1:0] ra, rb;
    int           order[5] = '{0, 1, 2, 3, 0};

    vecs[0] = '{4'b0001, 0, 16'h00FF, 16'h0001, 16'h00FC, 1'b0};
    vecs[1] = '{4'b0100, 2, 16'h8080, 16'h8080, 16'h0100, 1'b1};
    vecs[2] = '{4'b0010, 1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{4'b1000, 3, 16'hFFFF, 16'h0001, 16'hFFFC, 1'b0};
    vecs[4] = '{4'b0010, 1, 16'h1234, 16'h0100, 16'h1334, 1'b0};
    vecs[5] = '{4'b0001, 0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[6] = '{4'b0100, 2, 16'h0003, 16'h0003, 16'h0006, 1'b0};

    bus.req_valid  = '1;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    tick();
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_resp", {bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_cout}, 0);
`ifdef BK_ERR_MON_EN
    chk("rst_err", {bus.err_flag, bus.err_count, bus.err_dist_max}, 0);
`endif
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_vec(vecs[i].mask, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout);

    // All requesters active: order 0,1,2,3,0 with a grant every third cycle.
    pulse_reset();
    bus.resp_ready = 1'b1;
    bus.req_valid  = '1;
    gcnt     = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 20 && gcnt < 5; cyc++) begin
      #1;
      if (bus.req_ready != '0) begin
        gid = 0;
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) gid = i;
        chk("rr_onehot", 64'($countones(bus.req_ready)), 1);
        chk("rr_order", 64'(gid), 64'(order[gcnt]));
        if (gcnt > 0) chk("rr_spacing", 64'(cyc - last_cyc), 3);
        last_cyc = cyc;
        gcnt++;
      end
      tick();
    end
    chk("rr_grant_count", 64'(gcnt), 5);
    bus.req_valid = '0;
    tick();
    tick();
    tick();

    // Response backpressure: pointer is 1 here, requester 1 wins over 3.
    bus.resp_ready = 1'b0;
    bus.req_a[1*W +: W] = 16'h1234;
    bus.req_b[1*W +: W] = 16'h0100;
    bus.req_valid = 4'b1010;
    #1 chk("bp_grant", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    bus.req_valid = 4'b1000;
    tick();
    hold_sum = bus.resp_sum;
    chk("bp_sum", 64'(hold_sum), 64'(16'h1334));
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", {bus.resp_valid, bus.resp_id, bus.resp_sum, bus.req_ready},
          {1'b1, 2'd1, hold_sum, 4'b0000});
      tick();
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    #1 chk("bp_release", 64'(bus.resp_valid), 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("bp_single_resp", 64'(bus.resp_valid), 0);
      tick();
    end

    // Reset during CALC: pointer would be 3 without reset, so grant 0 proves it cleared.
    bus.req_a[2*W +: W] = 16'h0F0F;
    bus.req_b[2*W +: W] = 16'h0101;
    bus.req_valid = 4'b0100;
    #1 chk("abort_grant", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid = '0;
    #1 rst = 1'b1;
    #1 chk("abort_resp_valid", 64'(bus.resp_valid), 0);
    tick();
    rst = 1'b0;
    m_err_cnt  = 0;
    m_dist_max = '0;
    chk("abort_no_result", {bus.resp_valid, bus.resp_sum}, 0);
`ifdef BK_ERR_MON_EN
    chk("abort_err_count", 64'(bus.err_count), 0);
`endif
    run_vec(4'b1111, 0, 16'h00FF, 16'h0001, 16'h00FC, 1'b0);

    for (int t = 0; t < 10000; t++) begin
      rid = int'($urandom_range(0, NR - 1));
      ra  = W'($urandom);
      rb  = W'($urandom);
      r   = model(ra, rb);
      run_vec(4'b0001 << rid, rid, ra, rb, r[W-1:0], r[W]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
